secure_serdes_encrypt: RTL and testbench
========================================

Name:
secure_serdes_encrypt

Overview:
- Tiny-Tapeout-style top-level user block with bit-serial input and an encrypted byte output.
- After a start pulse, two 8-bit operands A and B are shifted in MSB first, one bit of each per clock.
- The block computes cipher = (A XOR B) XOR KEY, presents it in parallel on uo_out, and re-serialises it MSB first on a bidirectional pin.
- Sits directly under the chip harness; all I/O uses the standard ui/uo/uio buses.

Parameters:
- KEY, 8'h5A, fixed XOR key applied to A^B.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-high: 1 = reset, sampled on rising clk.
- ena  input  1  harness enable; ignored; no functional effect.
- ui_in  input  8  [0]=start, [1]=a_bit, [2]=b_bit; [7:3] unused.
- uo_out  output  8  cipher register.
- uio_in  input  8  unused, ignored.
- uio_out  output  8  [0]=done, [1]=ser_out, [2]=ser_valid, [3]=busy; [7:4]=0.
- uio_oe  output  8  constant 8'h0F (bits 3:0 driven, 7:4 inputs).

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - state=IDLE; A_sr, B_sr, cipher, tx_sr, count all cleared.
  - uo_out=0 and uio_out=0.
  - Reset overrides everything, including mid-shift or mid-transmit.
- States: IDLE, SHIFT, TX.
- IDLE:
  - busy=0.
  - start=1 at an edge → SHIFT with count=0.
  - done keeps its previous value until the next start, which clears it.
- SHIFT (busy=1):
  - Each edge does A_sr<={A_sr[6:0],a_bit} and B_sr<={B_sr[6:0],b_bit}, then count++.
  - start is ignored while in SHIFT.
- Load, on the edge that samples the 8th bit (count==7):
  - cipher <= ({A_sr[6:0],a_bit} ^ {B_sr[6:0],b_bit}) ^ KEY.
  - tx_sr gets the same value; done<=1; ser_valid<=1; state→TX.
- Latency: if start is sampled at edge N, data bits are sampled at edges N+1..N+8, and cipher/done are visible after edge N+8.
- TX (busy=1):
  - ser_out=tx_sr[7], ser_valid=1.
  - Each edge shifts tx_sr left and fills 0.
  - After 8 bits (edges N+9..N+16) ser_valid returns to 0 and state→IDLE.
  - ser_out is 0 whenever ser_valid=0.
- start in TX is ignored. start in IDLE on the same edge TX ends is not possible: TX→IDLE takes one edge, and start is only sampled in IDLE.
- uo_out holds cipher until the next load or reset; it does not change during SHIFT.
- All outputs are registered or constant; no combinational path from ui_in to outputs.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SHIFT, TX);
  - default KEY;
  - uio bit-index constants (DONE=0, SER=1, VALID=2, BUSY=3);
  - UIO_OE_MASK=8'h0F.
- One natural sub-module: serial_shift_reg8 (8-bit shift register with load, shift-in bit and MSB tap).
  - Instantiated for A_sr, B_sr and tx_sr.

Test Plan:
- Reset: assert rst_n=1 for 2 cycles with ui_in=0 → uo_out=0, uio_out=0, uio_oe=8'h0F.
- Basic encrypt: start pulse, then A=8'h02 and B=8'h03 MSB first → after 8th bit edge uo_out=8'h5B, done=1; ser_out over next 8 cycles = 0,1,0,1,1,0,1,1 with ser_valid=1; then ser_valid=0, busy=0.
- Key-only: A=8'hFF, B=8'hFF → uo_out=8'h5A; A=8'hC3, B=8'h5A → uo_out=8'hC3.
- Start ignored while busy: pulse start again at bit 3 of a transfer → result unchanged, still 8 bits sampled, completes at N+8.
- Reset mid-operation: assert reset after 4 bits → all outputs 0, state IDLE; a new full transfer then yields the correct cipher.
- Back-to-back: second start right after TX ends with A=8'hAA, B=8'h55 → done clears on start, then uo_out=8'hA5.

Source files
------------

// File: rtl/secure_serdes_encrypt_pkg.sv
// Shared definitions for the serial-in / encrypted-byte-out user block:
// controller states, default key and the uio bus bit assignments.
package secure_serdes_encrypt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TX    = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_KEY = 8'h5A;

    // Bit positions on uio_out
    localparam int UIO_DONE  = 0;
    localparam int UIO_SER   = 1;
    localparam int UIO_VALID = 2;
    localparam int UIO_BUSY  = 3;

    // Low nibble of uio is driven by this block, high nibble stays input
    localparam logic [7:0] UIO_OE_MASK = 8'h0F;

    // Serial bit counter width: eight bits per operand and per output byte
    localparam int CNT_W = 3;

endpackage

// File: rtl/secure_serdes_encrypt_serial_shift_reg8.sv
// 8-bit shift register with synchronous clear, parallel load and
// MSB-first shift (new bit enters at bit 0). Load wins over shift.
module serial_shift_reg8 (
    input  logic       clk,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       shift_i,
    input  logic       bit_i,
    output logic [7:0] data_o,
    output logic       msb_o
);

    logic [7:0] data_q;
    logic [7:0] data_d;

    // Next-state selection: load, shift or hold
    always_comb begin
        // NOTE: default assignment first so every path assigns data_d; no latch is inferred.
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {data_q[6:0], bit_i};
        end
    end

    // State register with synchronous clear
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for flops so all registers update together at the edge.
        if (clr_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign msb_o  = data_q[7];

endmodule

// File: rtl/secure_serdes_encrypt.sv
// Top-level user block: after a start pulse, shifts in operands A and B
// MSB first, publishes (A ^ B) ^ KEY on uo_out and re-serialises it MSB
// first on uio_out[1] with a valid strobe on uio_out[2].
module secure_serdes_encrypt
    import secure_serdes_encrypt_pkg::*;
#(
    parameter logic [7:0] KEY = DEFAULT_KEY
) (
    input  logic       clk,
    input  logic       rst_n,     // active-high synchronous reset
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       cipher_q;
    logic [7:0]       cipher_d;
    logic             done_q;
    logic             valid_q;
    logic             busy_q;

    logic             start;
    logic             a_bit;
    logic             b_bit;
    logic [7:0]       a_data;
    logic [7:0]       b_data;
    logic             tx_msb;
    logic             op_shift;
    logic             tx_load;
    logic             tx_shift;

    // Harness enable, bidirectional inputs and spare ui bits have no function
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

    assign start = ui_in[0];
    assign a_bit = ui_in[1];
    assign b_bit = ui_in[2];

    assign op_shift = (state_q == SHIFT);
    assign tx_load  = op_shift && (count_q == CNT_W'(7));
    assign tx_shift = (state_q == TX);

    // Cipher from the operand values including the bit sampled this edge
    assign cipher_d = ({a_data[6:0], a_bit} ^ {b_data[6:0], b_bit}) ^ KEY;

    serial_shift_reg8 u_a_sr (
        .clk         (clk),
        .clr_i       (rst_n),
        .load_i      (1'b0),
        .load_data_i (8'h00),
        .shift_i     (op_shift),
        .bit_i       (a_bit),
        .data_o      (a_data),
        .msb_o       ()
    );

    serial_shift_reg8 u_b_sr (
        .clk         (clk),
        .clr_i       (rst_n),
        .load_i      (1'b0),
        .load_data_i (8'h00),
        .shift_i     (op_shift),
        .bit_i       (b_bit),
        .data_o      (b_data),
        .msb_o       ()
    );

    serial_shift_reg8 u_tx_sr (
        .clk         (clk),
        .clr_i       (rst_n),
        .load_i      (tx_load),
        .load_data_i (cipher_d),
        .shift_i     (tx_shift),
        .bit_i       (1'b0),
        .data_o      (),
        .msb_o       (tx_msb)
    );

    // Controller FSM with registered status outputs and cipher register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            cipher_q <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(7)) begin
                        cipher_q <= cipher_d;
                        done_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        count_q  <= '0;
                        state_q  <= TX;
                    end
                end
                TX: begin
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(7)) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Pack status bits onto the bidirectional output bus
    always_comb begin
        uio_out            = 8'h00;
        uio_out[UIO_DONE]  = done_q;
        uio_out[UIO_SER]   = valid_q & tx_msb;
        uio_out[UIO_VALID] = valid_q;
        uio_out[UIO_BUSY]  = busy_q;
    end

    assign uo_out = cipher_q;
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_secure_serdes_encrypt.sv
// Self-checking bench for secure_serdes_encrypt. Expected ciphers are
// computed by the bench and queued when a transfer is driven, then popped
// and compared when the block reports done.
module tb_secure_serdes_encrypt;

    localparam logic [7:0] TB_KEY = 8'h5A;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    secure_serdes_encrypt dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound in case something stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge, then step off it for driving and sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ui_in = 8'h00;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uo_out: got %h want %h", uo_out, 8'h00);
        end
        n_checks++;
        if (uio_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uio_out: got %h want %h", uio_out, 8'h00);
        end
        n_checks++;
        if (uio_oe !== 8'h0F) begin
            n_fail++;
            $display("FAIL reset_uio_oe: got %h want %h", uio_oe, 8'h0F);
        end
        rst_n = 1'b0;
        tick();
    endtask

    // Full transfer: start pulse, 8 operand bits, then 8 serial output bits.
    // glitch_idx >= 0 raises start again while that operand bit is driven.
    task automatic run_transfer(input string tag, input logic [7:0] a,
                                input logic [7:0] b, input int glitch_idx);
        logic [7:0] exp;
        logic [7:0] prev_uo;
        prev_uo = uo_out;
        ui_in   = 8'h01;
        exp_q.push_back(a ^ b ^ TB_KEY);
        tick();  // edge N samples start
        n_checks++;
        if (uio_out[0] !== 1'b0 || uio_out[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_start: done/busy got %b/%b want 0/1", tag, uio_out[0], uio_out[3]);
        end
        for (int i = 0; i < 8; i++) begin
            ui_in = {5'b0, b[7-i], a[7-i], (i == glitch_idx) ? 1'b1 : 1'b0};
            if (i == 7) begin
                n_checks++;
                if (uo_out !== prev_uo || uio_out[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_shift_hold: uo_out/done got %h/%b want %h/0", tag, uo_out, uio_out[0], prev_uo);
                end
            end
            tick();
        end
        ui_in = 8'h00;
        // After edge N+8: cipher and done visible
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: queue empty at done", tag);
            exp = 8'hxx;
        end else begin
            exp = exp_q.pop_front();
        end
        n_checks++;
        if (uo_out !== exp || uio_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_cipher: uo_out/done got %h/%b want %h/1", tag, uo_out, uio_out[0], exp);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (uio_out[1] !== exp[7-k] || uio_out[2] !== 1'b1 || uio_out[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_ser_bit%0d: ser/valid/busy got %b/%b/%b want %b/1/1",
                         tag, k, uio_out[1], uio_out[2], uio_out[3], exp[7-k]);
            end
            // start during TX must be ignored
            ui_in = (k == 2) ? 8'h01 : 8'h00;
            tick();
        end
        ui_in = 8'h00;
        n_checks++;
        if (uio_out !== 8'h01 || uo_out !== exp) begin
            n_fail++;
            $display("FAIL %s_tx_end: uio_out/uo_out got %h/%h want %h/%h", tag, uio_out, uo_out, 8'h01, exp);
        end
    endtask

    task automatic test_basic_encrypt();
        run_transfer("basic", 8'h02, 8'h03, -1);
    endtask

    task automatic test_key_only();
        run_transfer("key_ff", 8'hFF, 8'hFF, -1);
        tick();
        run_transfer("key_c3", 8'hC3, 8'h5A, -1);
        tick();
    endtask

    task automatic test_start_ignored();
        run_transfer("start_busy", 8'h3C, 8'h81, 3);
        tick();
    endtask

    task automatic test_reset_mid();
        ui_in = 8'h01;
        tick();
        for (int i = 0; i < 4; i++) begin
            ui_in = {5'b0, 1'b1, 1'b0, 1'b0};
            tick();
        end
        ui_in = 8'h00;
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        n_checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: uo_out/uio_out got %h/%h want 00/00", uo_out, uio_out);
        end
        tick();
        n_checks++;
        if (uio_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_idle: uio_out got %h want 00", uio_out);
        end
        run_transfer("after_reset", 8'h96, 8'h0F, -1);
    endtask

    task automatic test_back_to_back();
        run_transfer("b2b_first", 8'h11, 8'h22, -1);
        run_transfer("b2b_second", 8'hAA, 8'h55, -1);
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'hA5;
        #1;
        test_reset();
        test_basic_encrypt();
        tick();
        test_key_only();
        test_start_ignored();
        test_reset_mid();
        tick();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
